// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decoded source/destination info in, stall decision and status out.
interface hazard_scoreboard_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_two_src;
    logic             id_wb_en;
    logic [3:0]       id_dest;
    logic             id_mem_read;
    logic             forward_en;
    logic             flush;
    logic             sram_ready;
    logic             hazard;
    logic             freeze;
    logic [3:0]       exe_dest;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest, id_mem_read,
        output forward_en, flush, sram_ready,
        input  hazard, freeze, exe_dest, stall_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest, id_mem_read,
        input  forward_en, flush, sram_ready,
        output hazard, freeze, exe_dest, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks register writes in flight through EXE/MEM/WB and stalls the ID instruction when
// forwarding cannot supply one of its operands.
module hazard_scoreboard #(
    parameter bit          WB_BYPASS = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave bus
);

    typedef struct packed {
        logic       v;
        logic       wb;
        logic [3:0] dest;
        logic       ld;
    } slot_t;

    slot_t            exe_q, mem_q, wb_q, exe_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             live, issue, hz;
    logic             exe_stall, mem_stall, wb_stall;

    // With forwarding on, only a load result is still unavailable to the next instruction.
    function automatic logic slot_stall(input slot_t s, input logic [3:0] r1,
                                        input logic [3:0] r2, input logic use2,
                                        input logic fwd);
        logic hit;
        hit = s.v & s.wb & ((s.dest == r1) | (use2 & (s.dest == r2)));
        return hit & (~fwd | s.ld);
    endfunction

    always_comb begin
        live      = bus.id_valid & ~bus.flush;
        exe_stall = slot_stall(exe_q, bus.id_src1, bus.id_src2, bus.id_two_src, bus.forward_en);
        mem_stall = slot_stall(mem_q, bus.id_src1, bus.id_src2, bus.id_two_src, bus.forward_en);
        wb_stall  = slot_stall(wb_q, bus.id_src1, bus.id_src2, bus.id_two_src, bus.forward_en);
        hz        = live & (exe_stall |
                            (~bus.forward_en & (mem_stall | (~WB_BYPASS & wb_stall))));
        issue     = live & ~hz;

        exe_d = '0;
        if (issue) begin
            exe_d = '{v: 1'b1, wb: bus.id_wb_en, dest: bus.id_dest, ld: bus.id_mem_read};
        end

        cnt_d = cnt_q;
        if (hz && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // A busy memory stage freezes every slot and the counter together.
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else if (bus.sram_ready) begin
            wb_q  <= mem_q;
            mem_q <= exe_q;
            exe_q <= exe_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.hazard    = hz;
    assign bus.freeze    = ~bus.sram_ready;
    assign bus.exe_dest  = exe_q.dest;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard against a behavioural pipeline model.
module tb_hazard_scoreboard;

    localparam bit WB_BYPASS = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.CNT_W(16)) bif ();
    hazard_scoreboard_if #(.CNT_W(8))  sif ();

    // Narrow-counter copy sees the same stimulus so saturation is reachable quickly.
    assign sif.id_valid    = bif.id_valid;
    assign sif.id_src1     = bif.id_src1;
    assign sif.id_src2     = bif.id_src2;
    assign sif.id_two_src  = bif.id_two_src;
    assign sif.id_wb_en    = bif.id_wb_en;
    assign sif.id_dest     = bif.id_dest;
    assign sif.id_mem_read = bif.id_mem_read;
    assign sif.forward_en  = bif.forward_en;
    assign sif.flush       = bif.flush;
    assign sif.sram_ready  = bif.sram_ready;

    hazard_scoreboard #(.WB_BYPASS(WB_BYPASS), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    hazard_scoreboard #(.WB_BYPASS(WB_BYPASS), .CNT_W(8)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    typedef struct packed {
        bit       v;
        bit       wb;
        bit [3:0] dest;
        bit       ld;
    } slot_t;

    slot_t       m_slot [3];   // 0 = EXE, 1 = MEM, 2 = WB
    int unsigned m_stalls = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_hazard();
        if (!bif.id_valid || bif.flush) return 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s == 2 && WB_BYPASS) continue;
            if (bif.forward_en && s != 0) continue;
            if (!m_slot[s].v || !m_slot[s].wb) continue;
            if (bif.forward_en && !m_slot[s].ld) continue;
            if (m_slot[s].dest == bif.id_src1) return 1'b1;
            if (bif.id_two_src && m_slot[s].dest == bif.id_src2) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int unsigned sat(input int unsigned n, input int unsigned lim);
        return (n > lim) ? lim : n;
    endfunction

    task automatic model_step(input bit hz);
        if (rst) begin
            for (int s = 0; s < 3; s++) m_slot[s] = '0;
            m_stalls = 0;
        end else if (bif.sram_ready) begin
            m_slot[2] = m_slot[1];
            m_slot[1] = m_slot[0];
            if (bif.id_valid && !bif.flush && !hz)
                m_slot[0] = '{v: 1'b1, wb: bif.id_wb_en, dest: bif.id_dest, ld: bif.id_mem_read};
            else
                m_slot[0] = '0;
            if (hz) m_stalls++;
        end
    endtask

    // One clock: compare at negedge, advance the model at posedge, return to #1 after it.
    task automatic cycle(output logic hz, output logic [15:0] cnt, output logic [3:0] ed,
                         output logic [7:0] scnt);
        bit mh;
        @(negedge clk);
        mh = model_hazard();
        check("hazard", 32'(bif.hazard), 32'(mh));
        check("sat_hazard", 32'(sif.hazard), 32'(mh));
        check("freeze", 32'(bif.freeze), 32'(!bif.sram_ready));
        check("exe_dest", 32'(bif.exe_dest), 32'(m_slot[0].dest));
        check("stall_cnt", 32'(bif.stall_cnt), sat(m_stalls, 65535));
        check("sat_stall_cnt", 32'(sif.stall_cnt), sat(m_stalls, 255));
        hz   = bif.hazard;
        cnt  = bif.stall_cnt;
        ed   = bif.exe_dest;
        scnt = sif.stall_cnt;
        @(posedge clk);
        model_step(mh);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                            input logic two, input logic wb, input logic [3:0] d,
                            input logic ld);
        bif.id_valid    = v;
        bif.id_src1     = s1;
        bif.id_src2     = s2;
        bif.id_two_src  = two;
        bif.id_wb_en    = wb;
        bif.id_dest     = d;
        bif.id_mem_read = ld;
    endtask

    task automatic idle();
        drive_id(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        bif.flush      = 1'b0;
        bif.sram_ready = 1'b1;
    endtask

    logic        h;
    logic [15:0] c;
    logic [3:0]  e;
    logic [7:0]  sc;

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle(h, c, e, sc);
        rst = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 3; s++) m_slot[s] = '0;
        idle();
        bif.forward_en = 1'b0;
        rst = 1'b1;
        cycle(h, c, e, sc);
        cycle(h, c, e, sc);
        rst = 1'b0;
        cycle(h, c, e, sc);
        check("rst_cnt", 32'(c), 32'd0);
        check("rst_exe_dest", 32'(e), 32'd0);
        check("rst_hazard", 32'(h), 32'd0);

        // No forwarding: ADD R1 then a reader of R1 stalls through EXE and MEM.
        bif.forward_en = 1'b0;
        drive_id(1'b1, 4'hA, 4'hB, 1'b0, 1'b1, 4'd1, 1'b0);
        cycle(h, c, e, sc);
        drive_id(1'b1, 4'd1, 4'hB, 1'b0, 1'b1, 4'd8, 1'b0);
        cycle(h, c, e, sc);  check("nofwd_hz1", 32'(h), 32'd1);
        cycle(h, c, e, sc);  check("nofwd_hz2", 32'(h), 32'd1);
        cycle(h, c, e, sc);  check("nofwd_hz3", 32'(h), 32'd0);
        idle();
        cycle(h, c, e, sc);  check("nofwd_cnt", 32'(c), 32'd2);

        // Load-use with forwarding: one bubble, then the ADD.
        do_reset();
        bif.forward_en = 1'b1;
        drive_id(1'b1, 4'hC, 4'hC, 1'b0, 1'b1, 4'd2, 1'b1);
        cycle(h, c, e, sc);
        drive_id(1'b1, 4'hD, 4'd2, 1'b1, 1'b1, 4'd5, 1'b0);
        cycle(h, c, e, sc);  check("lu_hz1", 32'(h), 32'd1);  check("lu_exe_ldr", 32'(e), 32'd2);
        cycle(h, c, e, sc);  check("lu_hz2", 32'(h), 32'd0);  check("lu_bubble", 32'(e), 32'd0);
        idle();
        cycle(h, c, e, sc);  check("lu_exe_add", 32'(e), 32'd5);  check("lu_cnt", 32'(c), 32'd1);

        // ALU result with forwarding: no stall.
        drive_id(1'b1, 4'hE, 4'hE, 1'b0, 1'b1, 4'd3, 1'b0);
        cycle(h, c, e, sc);
        drive_id(1'b1, 4'd3, 4'hE, 1'b0, 1'b1, 4'd8, 1'b0);
        cycle(h, c, e, sc);  check("fwd_hz", 32'(h), 32'd0);
        idle();
        cycle(h, c, e, sc);  check("fwd_exe", 32'(e), 32'd8);  check("fwd_cnt", 32'(c), 32'd1);

        // Load-use under a memory freeze: held stall, not counted until unfrozen.
        do_reset();
        drive_id(1'b1, 4'hE, 4'hE, 1'b0, 1'b1, 4'd4, 1'b1);
        cycle(h, c, e, sc);
        drive_id(1'b1, 4'd4, 4'h0, 1'b0, 1'b1, 4'd9, 1'b0);
        bif.sram_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(h, c, e, sc);
            check("frz_hz", 32'(h), 32'd1);
            check("frz_exe", 32'(e), 32'd4);
            check("frz_cnt", 32'(c), 32'd0);
        end
        bif.sram_ready = 1'b1;
        cycle(h, c, e, sc);  check("unfrz_hz1", 32'(h), 32'd1);
        cycle(h, c, e, sc);  check("unfrz_hz2", 32'(h), 32'd0);
        idle();
        cycle(h, c, e, sc);  check("unfrz_cnt", 32'(c), 32'd1);

        // Flush squashes a load-use stall and inserts a bubble.
        drive_id(1'b1, 4'hE, 4'hE, 1'b0, 1'b1, 4'd6, 1'b1);
        cycle(h, c, e, sc);
        drive_id(1'b1, 4'd6, 4'h0, 1'b0, 1'b1, 4'd7, 1'b0);
        bif.flush = 1'b1;
        cycle(h, c, e, sc);  check("flush_hz", 32'(h), 32'd0);
        bif.flush = 1'b0;
        idle();
        cycle(h, c, e, sc);  check("flush_bubble", 32'(e), 32'd0);

        // Reset in the middle of a stall.
        bif.forward_en = 1'b0;
        drive_id(1'b1, 4'hA, 4'hA, 1'b0, 1'b1, 4'd1, 1'b0);
        cycle(h, c, e, sc);
        drive_id(1'b1, 4'd1, 4'h0, 1'b0, 1'b1, 4'd2, 1'b0);
        cycle(h, c, e, sc);  check("mid_hz", 32'(h), 32'd1);
        rst = 1'b1;
        cycle(h, c, e, sc);
        rst = 1'b0;
        cycle(h, c, e, sc);  check("post_rst_hz", 32'(h), 32'd0);  check("post_rst_cnt", 32'(c), 32'd0);

        // Self-dependent stream: stalls accumulate past the narrow counter's ceiling.
        drive_id(1'b1, 4'd1, 4'h0, 1'b0, 1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 420; i++) cycle(h, c, e, sc);
        check("sat_final", 32'(sc), 32'd255);

        // Random traffic with a small register pool to provoke frequent matches.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive_id(1'b1, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3)),
                     1'($urandom));
            bif.id_valid   = ($urandom_range(0, 4) != 0);
            bif.forward_en = 1'($urandom);
            bif.flush      = ($urandom_range(0, 9) == 0);
            bif.sram_ready = ($urandom_range(0, 4) != 0);
            rst            = ($urandom_range(0, 99) == 0);
            cycle(h, c, e, sc);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
